bcd_up_counter: RTL and testbench

- Consumes the slow divided clock level produced by the clock divider (50%-duty square wave, e.g. 1 Hz from 100 MHz) and counts its rising edges as a DIGITS-wide BCD up counter.
- Runs entirely in the i_clk domain. The divided clock is treated as data: it is synchronized, edge-detected and used as a count enable, never as a clock.
- Provides run/stop toggle and clear controls. Drives the BCD digits to the downstream display stage.

---
 rtl/bcd_up_counter_pkg.sv | 13 +
 rtl/bcd_up_counter_sync_edge_detect.sv | 29 ++
 rtl/bcd_up_counter.sv | 105 ++++++++++
 tb/tb_bcd_up_counter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_up_counter_pkg.sv
// Shared constants for the BCD up counter.
// Holds the state encoding and BCD digit limits.
package bcd_up_counter_pkg;

  localparam logic STOPPED = 1'b0;
  localparam logic RUNNING = 1'b1;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] MAX_DIGIT = 4'd9;

  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/bcd_up_counter_sync_edge_detect.sv
// Synchronizer chain plus history flop.
// o_rise is a one-cycle pulse per synchronized rising edge.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_async};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign o_level = sync_q[SYNC_STAGES-1];
  assign o_rise  = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/bcd_up_counter.sv
// BCD up counter driven by a divided clock level used as data.
// Run/stop toggles on button edges; clear forces the count to zero.
module bcd_up_counter
  import bcd_up_counter_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_tick_clk,
  input  logic                      i_run_stop,
  input  logic                      i_clear,
  output logic [BCD_W*DIGITS-1:0]   o_bcd,
  output logic                      o_running,
  output logic                      o_tick,
  output logic                      o_wrap
);

  logic tick_rise;
  logic rs_rise;
  logic tick_lvl;
  logic rs_lvl;
  logic unused_lvl;

  logic                    state_q, state_d;
  logic [BCD_W*DIGITS-1:0] bcd_q, bcd_d;
  logic                    wrap_q, wrap_d;
  logic [DIGITS-1:0]       nine;
  logic                    inc;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_tick_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_async (i_tick_clk),
    .o_level (tick_lvl),
    .o_rise  (tick_rise)
  );

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rs_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_async (i_run_stop),
    .o_level (rs_lvl),
    .o_rise  (rs_rise)
  );

  assign unused_lvl = tick_lvl ^ rs_lvl;

  always_comb begin
    state_d = state_q;
    case (state_q)
      STOPPED: if (rs_rise) state_d = RUNNING;
      RUNNING: if (rs_rise) state_d = STOPPED;
      default: state_d = STOPPED;
    endcase
  end

  // The registered state decides whether a tick counts, so a
  // simultaneous toggle is governed by the pre-toggle state.
  assign inc = tick_rise & (state_q == RUNNING);

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    logic [BCD_W-1:0] dig;
    logic             cin;

    assign dig     = bcd_q[k*BCD_W +: BCD_W];
    assign nine[k] = (dig == MAX_DIGIT);

    if (k == 0) begin : g_lsd
      assign cin = 1'b1;
    end else begin : g_upper
      assign cin = &nine[k-1:0];
    end

    assign bcd_d[k*BCD_W +: BCD_W] =
      i_clear      ? '0 :
      (inc & cin)  ? ((dig == MAX_DIGIT) ? '0 : dig + 4'd1) :
                     dig;
  end

  assign wrap_d = ~i_clear & inc & (&nine);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= STOPPED;
      bcd_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      wrap_q  <= wrap_d;
    end
  end

  assign o_bcd     = bcd_q;
  assign o_running = (state_q == RUNNING);
  assign o_tick    = tick_rise;
  assign o_wrap    = wrap_q;

endmodule

// File: tb/tb_bcd_up_counter.sv
// Scoreboard bench for bcd_up_counter with an integer reference model.
// Expected responses are queued per tick and checked by a monitor.
module tb_bcd_up_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick_in = 1'b0;
  logic        rs_in = 1'b0;
  logic        clr_in = 1'b0;
  logic [15:0] bcd;
  logic        running;
  logic        tick_o;
  logic        wrap_o;

  bcd_up_counter #(
    .DIGITS      (4),
    .SYNC_STAGES (2)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_tick_clk (tick_in),
    .i_run_stop (rs_in),
    .i_clear    (clr_in),
    .o_bcd      (bcd),
    .o_running  (running),
    .o_tick     (tick_o),
    .o_wrap     (wrap_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bcd;
    logic        wrap;
    logic        run;
  } exp_t;

  exp_t q[$];

  int tests = 0;
  int fails = 0;

  int cnt     = 0;
  bit run_m   = 1'b0;
  int ticks_m = 0;
  int wraps_m = 0;

  int tick_seen = 0;
  int wrap_seen = 0;

  always @(negedge clk) begin
    if (tick_o === 1'b1) tick_seen <= tick_seen + 1;
    if (wrap_o === 1'b1) wrap_seen <= wrap_seen + 1;
  end

  function automatic logic [15:0] to_bcd(int n);
    logic [15:0] r;
    int d;
    d = n;
    for (int k = 0; k < 4; k++) begin
      r[k*4 +: 4] = 4'(d % 10);
      d = d / 10;
    end
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: apply one stimulus event at the abstract level.
  function automatic void model(bit t, bit r, bit c);
    bit w;
    exp_t e;
    w = 1'b0;
    if (c) begin
      cnt = 0;
    end else if (t && run_m) begin
      w   = (cnt == 9999);
      cnt = (cnt + 1) % 10000;
    end
    if (t) begin
      ticks_m++;
      if (w) wraps_m++;
      e.bcd  = to_bcd(cnt);
      e.wrap = w;
      e.run  = run_m ^ r;
      q.push_back(e);
    end
    run_m = run_m ^ r;
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (tick_o === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_tick", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          @(posedge clk);
          #1;
          chk("sb_bcd", 32'(bcd), 32'(e.bcd));
          chk("sb_wrap", 32'(wrap_o), 32'(e.wrap));
          chk("sb_run", 32'(running), 32'(e.run));
        end
      end
    end
  end

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  task automatic evt(bit t, bit r, bit c, int hi, int gap);
    @(negedge clk);
    model(t, r, c);
    tick_in = t;
    rs_in   = r;
    clr_in  = c;
    repeat (hi) @(negedge clk);
    tick_in = 1'b0;
    rs_in   = 1'b0;
    clr_in  = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic burst(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      model(1'b1, 1'b0, 1'b0);
      tick_in = 1'b1;
      @(negedge clk);
      tick_in = 1'b0;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic tick_rand();
    evt(1'b1, 1'b0, 1'b0, $urandom_range(3, 6), $urandom_range(3, 9));
  endtask

  initial begin
    logic [15:0] old;
    int          ts;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_bcd", 32'(bcd), 32'h0);
    chk("reset_run", 32'(running), 32'h0);
    chk("reset_wrap", 32'(wrap_o), 32'h0);

    evt(1'b0, 1'b1, 1'b0, 3, 4);
    chk("run_on", 32'(running), 32'h1);

    // First tick: check the three-edge latency explicitly.
    old = bcd;
    @(negedge clk);
    model(1'b1, 1'b0, 1'b0);
    tick_in = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("lat_hold", 32'(bcd), 32'(old));
    chk("lat_tick", 32'(tick_o), 32'h1);
    @(posedge clk);
    #1;
    chk("lat_update", 32'(bcd), 32'h0001);
    chk("lat_tick_gone", 32'(tick_o), 32'h0);
    @(negedge clk);
    tick_in = 1'b0;
    repeat (6) @(negedge clk);

    repeat (4) tick_rand();
    chk("count5", 32'(bcd), 32'h0005);
    chk("count5_run", 32'(running), 32'h1);

    evt(1'b0, 1'b1, 1'b0, 3, 4);
    @(posedge clk);
    ts = tick_seen;
    repeat (3) tick_rand();
    @(posedge clk);
    chk("stopped_hold", 32'(bcd), 32'h0005);
    chk("stopped_ticks", 32'(tick_seen - ts), 32'd3);
    chk("stopped_run", 32'(running), 32'h0);

    evt(1'b0, 1'b1, 1'b0, 3, 4);
    burst(9 - cnt);
    chk("at_9", 32'(bcd), 32'h0009);
    tick_rand();
    chk("carry_10", 32'(bcd), 32'h0010);
    burst(99 - cnt);
    tick_rand();
    chk("carry_100", 32'(bcd), 32'h0100);
    burst(9999 - cnt);
    chk("at_9999", 32'(bcd), 32'h9999);
    tick_rand();
    @(posedge clk);
    chk("wrap_0", 32'(bcd), 32'h0000);
    chk("wrap_once", 32'(wrap_seen), 32'd1);

    burst(42);
    chk("at_42", 32'(bcd), 32'h0042);
    evt(1'b1, 1'b0, 1'b1, 4, 4);
    chk("clear_zero", 32'(bcd), 32'h0000);
    chk("clear_run", 32'(running), 32'h1);

    burst(7);
    old = bcd;
    evt(1'b1, 1'b1, 1'b0, 3, 5);
    chk("sim_r2s", 32'(bcd), 32'h0008);
    chk("sim_r2s_run", 32'(running), 32'h0);
    evt(1'b1, 1'b1, 1'b0, 3, 5);
    chk("sim_s2r", 32'(bcd), 32'h0008);
    chk("sim_s2r_run", 32'(running), 32'h1);

    for (int i = 0; i < 40; i++) begin
      evt(1'($urandom_range(0, 1)),
          ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 5) == 0),
          $urandom_range(3, 5), $urandom_range(2, 8));
      chk("rand_bcd", 32'(bcd), 32'(to_bcd(cnt)));
      chk("rand_run", 32'(running), 32'(run_m));
    end

    if (!run_m) evt(1'b0, 1'b1, 1'b0, 3, 4);
    if (cnt != 0) evt(1'b0, 1'b0, 1'b1, 3, 4);
    burst(123);
    chk("at_123", 32'(bcd), 32'h0123);

    // Tick edge sits in the sync chain when reset hits.
    @(negedge clk);
    tick_in = 1'b1;
    @(negedge clk);
    rst     = 1'b1;
    tick_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cnt   = 0;
    run_m = 1'b0;
    repeat (8) @(negedge clk);
    @(posedge clk);
    chk("rst_mid_bcd", 32'(bcd), 32'h0);
    chk("rst_mid_run", 32'(running), 32'h0);
    chk("rst_mid_ticks", 32'(tick_seen), 32'(ticks_m));

    repeat (10) @(negedge clk);
    @(posedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    chk("tick_total", 32'(tick_seen), 32'(ticks_m));
    chk("wrap_total", 32'(wrap_seen), 32'(wraps_m));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
